// File: rtl/hmmm_pkg.sv
// Shared constants and types for the Hmmm microsequencer.
package hmmm_pkg;

    localparam logic [3:0] OP_HALT   = 4'h0;
    localparam logic [3:0] OP_SETN   = 4'h1;
    localparam logic [3:0] OP_LOADN  = 4'h2;
    localparam logic [3:0] OP_STOREN = 4'h3;
    localparam logic [3:0] OP_MEMR   = 4'h4;  // loadr / storer, split by rZ
    localparam logic [3:0] OP_ADD    = 4'h6;
    localparam logic [3:0] OP_SUB    = 4'h7;
    localparam logic [3:0] OP_JUMPN  = 4'hB;
    localparam logic [3:0] OP_JEQZN  = 4'hC;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE, S_F0, S_F1, S_DEC, S_E0, S_E1, S_E2, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_HALT, C_SETN, C_LOADN, C_STOREN, C_LOADR, C_STORER,
        C_ADD, C_SUB, C_JUMPN, C_JEQZN, C_ILLEGAL
    } iclass_t;

endpackage

// File: rtl/hmmm_ctrl_if.sv
// Control bundle between the microsequencer (master) and the datapath (slave).
interface hmmm_ctrl_if;

    logic        run;
    logic [15:0] ir_q;
    logic        bus_zero;

    logic        pc_out;
    logic        ram_out;
    logic        ir_out;
    logic        reg_out;
    logic        alu_out;

    logic        mar_in;
    logic        ir_in;
    logic        pc_in;
    logic        pc_inc;
    logic        ram_in;
    logic        reg_in;
    logic        alu_a_in;
    logic        alu_b_in;
    logic        alu_op;
    logic [3:0]  reg_sel;

    logic        halted;
    logic        illegal;

    modport master (
        input  run, ir_q, bus_zero,
        output pc_out, ram_out, ir_out, reg_out, alu_out,
               mar_in, ir_in, pc_in, pc_inc, ram_in, reg_in,
               alu_a_in, alu_b_in, alu_op, reg_sel, halted, illegal
    );

    modport slave (
        output run, ir_q, bus_zero,
        input  pc_out, ram_out, ir_out, reg_out, alu_out,
               mar_in, ir_in, pc_in, pc_inc, ram_in, reg_in,
               alu_a_in, alu_b_in, alu_op, reg_sel, halted, illegal
    );

endinterface

// File: rtl/hmmm_decode.sv
// Combinational instruction classifier for the IR contents.
module hmmm_decode
    import hmmm_pkg::*;
(
    input  logic [15:0] ir_q,
    output iclass_t     iclass,
    output logic [3:0]  rx,
    output logic [3:0]  ry,
    output logic [3:0]  rz,
    output logic        legal
);

    // Split fields and map the opcode (plus qualifying fields) to a class
    always_comb begin
        rx     = ir_q[11:8];
        ry     = ir_q[7:4];
        rz     = ir_q[3:0];
        iclass = C_ILLEGAL;
        case (ir_q[15:12])
            OP_HALT:   iclass = (ir_q == 16'h0000) ? C_HALT : C_ILLEGAL;
            OP_SETN:   iclass = C_SETN;
            OP_LOADN:  iclass = C_LOADN;
            OP_STOREN: iclass = C_STOREN;
            OP_MEMR: begin
                if (ir_q[3:0] == 4'h0)      iclass = C_LOADR;
                else if (ir_q[3:0] == 4'h1) iclass = C_STORER;
                else                        iclass = C_ILLEGAL;
            end
            OP_ADD:    iclass = C_ADD;
            OP_SUB:    iclass = C_SUB;
            OP_JUMPN:  iclass = (ir_q[11:8] == 4'h0) ? C_JUMPN : C_ILLEGAL;
            OP_JEQZN:  iclass = C_JEQZN;
            default:   iclass = C_ILLEGAL;
        endcase
        legal = (iclass != C_ILLEGAL);
    end

endmodule

// File: rtl/hmmm_ctrl.sv
// Hmmm microsequencer: fetch, decode, execute with one bus driver per cycle.
module hmmm_ctrl
    import hmmm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    hmmm_ctrl_if.master bus
);

    state_t    state, state_nxt, done_state;
    logic      illegal_q, illegal_nxt;
    iclass_t   iclass;
    logic [3:0] rx, ry, rz;
    logic      legal;

    hmmm_decode u_decode (
        .ir_q   (bus.ir_q),
        .iclass (iclass),
        .rx     (rx),
        .ry     (ry),
        .rz     (rz),
        .legal  (legal)
    );

    // State register and sticky illegal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            illegal_q <= illegal_nxt;
        end
    end

    // Next-state selection; run is only consulted at instruction boundaries
    always_comb begin
        state_nxt   = state;
        illegal_nxt = illegal_q;
        done_state  = bus.run ? S_F0 : S_IDLE;
        case (state)
            S_IDLE: if (bus.run) state_nxt = S_F0;
            S_F0:   state_nxt = S_F1;
            S_F1:   state_nxt = S_DEC;
            S_DEC: begin
                if (iclass == C_HALT) begin
                    state_nxt = S_HALT;
                end else if (!legal) begin
                    state_nxt   = S_HALT;
                    illegal_nxt = 1'b1;
                end else begin
                    state_nxt = S_E0;
                end
            end
            S_E0: begin
                case (iclass)
                    C_SETN, C_JUMPN: state_nxt = done_state;
                    C_JEQZN:         state_nxt = bus.bus_zero ? S_E1 : done_state;
                    default:         state_nxt = S_E1;
                endcase
            end
            S_E1:   state_nxt = (iclass == C_ADD || iclass == C_SUB) ? S_E2 : done_state;
            S_E2:   state_nxt = done_state;
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control decode from state and IR; reset masks every output
    always_comb begin
        bus.pc_out   = 1'b0;
        bus.ram_out  = 1'b0;
        bus.ir_out   = 1'b0;
        bus.reg_out  = 1'b0;
        bus.alu_out  = 1'b0;
        bus.mar_in   = 1'b0;
        bus.ir_in    = 1'b0;
        bus.pc_in    = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.ram_in   = 1'b0;
        bus.reg_in   = 1'b0;
        bus.alu_a_in = 1'b0;
        bus.alu_b_in = 1'b0;
        bus.alu_op   = ALU_ADD;
        bus.reg_sel  = '0;
        bus.halted   = 1'b0;
        bus.illegal  = 1'b0;
        if (!rst) begin
            case (state)
                S_F0: begin
                    bus.pc_out = 1'b1;
                    bus.mar_in = 1'b1;
                end
                S_F1: begin
                    bus.ram_out = 1'b1;
                    bus.ir_in   = 1'b1;
                    bus.pc_inc  = 1'b1;
                end
                S_E0: begin
                    case (iclass)
                        C_SETN: begin
                            bus.ir_out  = 1'b1;
                            bus.reg_in  = 1'b1;
                            bus.reg_sel = rx;
                        end
                        C_LOADN, C_STOREN: begin
                            bus.ir_out = 1'b1;
                            bus.mar_in = 1'b1;
                        end
                        C_LOADR, C_STORER: begin
                            bus.reg_out = 1'b1;
                            bus.reg_sel = ry;
                            bus.mar_in  = 1'b1;
                        end
                        C_ADD, C_SUB: begin
                            bus.reg_out  = 1'b1;
                            bus.reg_sel  = ry;
                            bus.alu_a_in = 1'b1;
                        end
                        C_JUMPN: begin
                            bus.ir_out = 1'b1;
                            bus.pc_in  = 1'b1;
                        end
                        C_JEQZN: begin
                            bus.reg_out = 1'b1;
                            bus.reg_sel = rx;
                        end
                        default: ;
                    endcase
                end
                S_E1: begin
                    case (iclass)
                        C_LOADN, C_LOADR: begin
                            bus.ram_out = 1'b1;
                            bus.reg_in  = 1'b1;
                            bus.reg_sel = rx;
                        end
                        C_STOREN, C_STORER: begin
                            bus.reg_out = 1'b1;
                            bus.reg_sel = rx;
                            bus.ram_in  = 1'b1;
                        end
                        C_ADD, C_SUB: begin
                            bus.reg_out  = 1'b1;
                            bus.reg_sel  = rz;
                            bus.alu_b_in = 1'b1;
                        end
                        C_JEQZN: begin
                            bus.ir_out = 1'b1;
                            bus.pc_in  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_E2: begin
                    bus.alu_out = 1'b1;
                    bus.reg_in  = 1'b1;
                    bus.reg_sel = rx;
                    bus.alu_op  = (iclass == C_SUB) ? ALU_SUB : ALU_ADD;
                end
                S_HALT: begin
                    bus.halted  = 1'b1;
                    bus.illegal = illegal_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hmmm_ctrl.sv
// Self-checking bench for hmmm_ctrl against a per-instruction control-word model.
module tb_hmmm_ctrl;

    typedef struct packed {
        logic       pc_out, ram_out, ir_out, reg_out, alu_out;
        logic       mar_in, ir_in, pc_in, pc_inc, ram_in, reg_in;
        logic       alu_a_in, alu_b_in, alu_op;
        logic [3:0] reg_sel;
        logic       halted, illegal;
    } ctl_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    ctl_t exp_q[$];

    always #5 clk = ~clk;

    hmmm_ctrl_if bus ();

    hmmm_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ctl_t observe();
        ctl_t c;
        c.pc_out   = bus.pc_out;   c.ram_out  = bus.ram_out;
        c.ir_out   = bus.ir_out;   c.reg_out  = bus.reg_out;
        c.alu_out  = bus.alu_out;  c.mar_in   = bus.mar_in;
        c.ir_in    = bus.ir_in;    c.pc_in    = bus.pc_in;
        c.pc_inc   = bus.pc_inc;   c.ram_in   = bus.ram_in;
        c.reg_in   = bus.reg_in;   c.alu_a_in = bus.alu_a_in;
        c.alu_b_in = bus.alu_b_in; c.alu_op   = bus.alu_op;
        c.reg_sel  = bus.reg_sel;  c.halted   = bus.halted;
        c.illegal  = bus.illegal;
        return c;
    endfunction

    function automatic ctl_t f0_word();
        ctl_t c = '0;
        c.pc_out = 1'b1;
        c.mar_in = 1'b1;
        return c;
    endfunction

    // Reference: list of control words, one per cycle, from F0 to the last
    // execute step. Returns 0 = normal end, 1 = halt, 2 = illegal.
    function automatic int build_exp(input logic [15:0] ins, input logic bz);
        ctl_t c;
        logic [3:0] op, rx, ry, rz;
        int kind;
        op = ins[15:12]; rx = ins[11:8]; ry = ins[7:4]; rz = ins[3:0];
        kind = 0;
        exp_q.delete();
        exp_q.push_back(f0_word());
        c = '0; c.ram_out = 1; c.ir_in = 1; c.pc_inc = 1; exp_q.push_back(c);
        c = '0; exp_q.push_back(c);
        if (ins == 16'h0000) return 1;
        case (op)
            4'h1: begin c = '0; c.ir_out = 1; c.reg_in = 1; c.reg_sel = rx; exp_q.push_back(c); end
            4'h2, 4'h3: begin
                c = '0; c.ir_out = 1; c.mar_in = 1; exp_q.push_back(c);
                c = '0; c.reg_sel = rx;
                if (op == 4'h2) begin c.ram_out = 1; c.reg_in = 1; end
                else begin c.reg_out = 1; c.ram_in = 1; end
                exp_q.push_back(c);
            end
            4'h4: begin
                if (rz > 4'h1) kind = 2;
                else begin
                    c = '0; c.reg_out = 1; c.reg_sel = ry; c.mar_in = 1; exp_q.push_back(c);
                    c = '0; c.reg_sel = rx;
                    if (rz == 4'h0) begin c.ram_out = 1; c.reg_in = 1; end
                    else begin c.reg_out = 1; c.ram_in = 1; end
                    exp_q.push_back(c);
                end
            end
            4'h6, 4'h7: begin
                c = '0; c.reg_out = 1; c.reg_sel = ry; c.alu_a_in = 1; exp_q.push_back(c);
                c = '0; c.reg_out = 1; c.reg_sel = rz; c.alu_b_in = 1; exp_q.push_back(c);
                c = '0; c.alu_out = 1; c.reg_in = 1; c.reg_sel = rx;
                c.alu_op = (op == 4'h7); exp_q.push_back(c);
            end
            4'hB: begin
                if (rx != 4'h0) kind = 2;
                else begin c = '0; c.ir_out = 1; c.pc_in = 1; exp_q.push_back(c); end
            end
            4'hC: begin
                c = '0; c.reg_out = 1; c.reg_sel = rx; exp_q.push_back(c);
                if (bz) begin c = '0; c.ir_out = 1; c.pc_in = 1; exp_q.push_back(c); end
            end
            default: kind = 2;
        endcase
        return kind;
    endfunction

    // Runs one instruction from F0. mode 0: run held 1; 1: run random each
    // cycle; 2: run dropped from F1 onward. Leaves the DUT in F0 or HALT.
    task automatic do_instr(input string name, input logic [15:0] ins, input logic bz,
                            input int mode, output int kind);
        ctl_t act, exp, hw;
        logic fin_run;
        int   n;
        bus.ir_q = ins;
        bus.bus_zero = bz;
        kind = build_exp(ins, bz);
        n = exp_q.size();
        fin_run = 1'b1;
        for (int i = 0; i < n; i++) begin
            act = observe();
            checks++;
            if (act !== exp_q[i]) begin
                errors++;
                $display("FAIL %s cyc%0d ctl act=%h exp=%h", name, i, act, exp_q[i]);
            end
            checks++;
            if ($countones({act.pc_out, act.ram_out, act.ir_out, act.reg_out, act.alu_out}) > 1) begin
                errors++;
                $display("FAIL %s cyc%0d onehot drivers act=%b exp<=1", name, i,
                         {act.pc_out, act.ram_out, act.ir_out, act.reg_out, act.alu_out});
            end
            case (mode)
                0:       bus.run = 1'b1;
                1:       bus.run = 1'($urandom_range(0, 1));
                default: bus.run = (i == 0);
            endcase
            fin_run = bus.run;
            tick();
        end
        if (kind == 0) begin
            exp = fin_run ? f0_word() : ctl_t'('0);
            act = observe();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s next ctl act=%h exp=%h run=%0b", name, act, exp, fin_run);
            end
            if (!fin_run) begin
                bus.run = 1'b1;
                tick();
            end
        end else begin
            hw = '0; hw.halted = 1'b1; hw.illegal = (kind == 2);
            for (int k = 0; k < 4; k++) begin
                bus.run = 1'($urandom_range(0, 1));
                act = observe();
                checks++;
                if (act !== hw) begin
                    errors++;
                    $display("FAIL %s halt%0d ctl act=%h exp=%h", name, k, act, hw);
                end
                tick();
            end
        end
    endtask

    // Reset pulse from any state, ends in F0 with run=1
    task automatic reset_to_f0(input string name);
        ctl_t act;
        rst = 1'b1;
        bus.run = 1'b1;
        #1;
        act = observe();
        checks++;
        if (act !== ctl_t'('0)) begin
            errors++;
            $display("FAIL %s in-reset ctl act=%h exp=0", name, act);
        end
        tick();
        rst = 1'b0;
        #1;
        act = observe();
        checks++;
        if (act !== ctl_t'('0)) begin
            errors++;
            $display("FAIL %s idle-after-reset ctl act=%h exp=0", name, act);
        end
        tick();
        act = observe();
        checks++;
        if (act !== f0_word()) begin
            errors++;
            $display("FAIL %s f0-after-reset ctl act=%h exp=%h", name, act, f0_word());
        end
    endtask

    task automatic test_reset();
        ctl_t act;
        rst = 1'b1;
        bus.run = 1'b0;
        bus.ir_q = 16'h6123;
        bus.bus_zero = 1'b1;
        tick();
        tick();
        act = observe();
        checks++;
        if (act !== ctl_t'('0)) begin
            errors++;
            $display("FAIL reset ctl act=%h exp=0", act);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            act = observe();
            checks++;
            if (act !== ctl_t'('0)) begin
                errors++;
                $display("FAIL idle_hold%0d ctl act=%h exp=0", i, act);
            end
        end
        bus.run = 1'b1;
        tick();
        act = observe();
        checks++;
        if (act !== f0_word()) begin
            errors++;
            $display("FAIL idle_to_f0 ctl act=%h exp=%h", act, f0_word());
        end
    endtask

    task automatic test_exec_basic();
        int kind;
        do_instr("setn", 16'h152A, 1'b0, 0, kind);
        do_instr("add", 16'h6123, 1'b1, 0, kind);
        do_instr("sub", 16'h7A5F, 1'b0, 0, kind);
        do_instr("jeqzn_taken", 16'hC410, 1'b1, 0, kind);
        do_instr("jeqzn_not", 16'hC410, 1'b0, 0, kind);
        do_instr("jumpn", 16'hB077, 1'b1, 0, kind);
        do_instr("loadr", 16'h4370, 1'b0, 0, kind);
        do_instr("storer", 16'h4391, 1'b0, 0, kind);
    endtask

    task automatic test_halt();
        ctl_t act, hw;
        int kind;
        do_instr("halt", 16'h0000, 1'b0, 0, kind);
        hw = '0; hw.halted = 1'b1;
        bus.run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            act = observe();
            checks++;
            if (act !== hw) begin
                errors++;
                $display("FAIL halt_stay%0d ctl act=%h exp=%h", i, act, hw);
            end
            tick();
        end
        reset_to_f0("halt_rst");
    endtask

    task automatic test_illegal();
        int kind;
        do_instr("illegal_4122", 16'h4122, 1'b0, 0, kind);
        reset_to_f0("illegal_rst");
        do_instr("illegal_b1", 16'hB105, 1'b0, 0, kind);
        reset_to_f0("illegal_b1_rst");
    endtask

    task automatic test_storen_interrupts();
        ctl_t act, e0;
        int kind;
        logic saw_ram_in;
        saw_ram_in = 1'b0;
        bus.ir_q = 16'h3207;
        bus.bus_zero = 1'b0;
        bus.run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            saw_ram_in |= bus.ram_in;
            tick();
        end
        e0 = '0; e0.ir_out = 1'b1; e0.mar_in = 1'b1;
        act = observe();
        checks++;
        if (act !== e0) begin
            errors++;
            $display("FAIL storen_e0 ctl act=%h exp=%h", act, e0);
        end
        saw_ram_in |= bus.ram_in;
        reset_to_f0("storen_rst_e0");
        checks++;
        if (saw_ram_in !== 1'b0) begin
            errors++;
            $display("FAIL storen_rst_no_ram_in act=%b exp=0", saw_ram_in);
        end
        do_instr("storen_run_drop", 16'h3207, 1'b0, 2, kind);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        logic [3:0]  op;
        r = 16'($urandom);
        case ($urandom_range(0, 11))
            0:  r = 16'h0000;
            1:  r[15:12] = 4'h1;
            2:  r[15:12] = 4'h2;
            3:  r[15:12] = 4'h3;
            4:  begin r[15:12] = 4'h4; r[3:1] = 3'b000; end
            5:  r[15:12] = 4'h6;
            6:  r[15:12] = 4'h7;
            7:  begin r[15:12] = 4'hB; r[11:8] = 4'h0; end
            8:  r[15:12] = 4'hC;
            9:  begin r[15:12] = 4'h4; r[3:0] = 4'($urandom_range(2, 15)); end
            10: begin r[15:12] = 4'hB; r[11:8] = 4'($urandom_range(1, 15)); end
            default: begin
                op = 4'($urandom_range(0, 6));
                case (op)
                    4'd0: op = 4'h5;
                    4'd1: op = 4'h8;
                    4'd2: op = 4'h9;
                    4'd3: op = 4'hA;
                    4'd4: op = 4'hD;
                    4'd5: op = 4'hE;
                    default: op = 4'hF;
                endcase
                r[15:12] = op;
            end
        endcase
        return r;
    endfunction

    task automatic test_back_to_back();
        int kind;
        logic [15:0] ins;
        for (int t = 0; t < 60; t++) begin
            ins = rand_instr();
            do_instr("rand", ins, 1'($urandom_range(0, 1)), (t % 2 == 0) ? 0 : 1, kind);
            if (kind != 0) reset_to_f0("rand_rst");
        end
    endtask

    initial begin
        test_reset();
        test_exec_basic();
        test_halt();
        test_illegal();
        test_storen_interrupts();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
